// File: rtl/taxi_axis_fifo_pause_ctrl.sv
// ----------------------------------------------------------------------------
// taxi_axis_fifo_pause_ctrl
//
// Watermark/hysteresis pause sequencer for the m-side pause port of an
// AXI4-Stream FIFO. The FIFO output is held paused while data accumulates,
// and a burst is released once the depth reaches HI_WM or a hold timeout
// expires. A level software pause overrides any release, and a missing
// pause_ack edge (in either direction) raises a sticky error.
//
// Optional feature macro: TAXI_PAUSE_CTRL_STATS_EN
//   defined     -> pause_cnt / force_rel_cnt are live 32-bit wrapping counters
//   not defined -> both outputs tied to 32'd0, no counter registers
//
// Ports
//   clk             in   FIFO m_clk
//   rst_n           in   asynchronous active-low reset
//   enable          in   1 = watermark pausing active, 0 = sw_pause only
//   sw_pause        in   software pause request (level)
//   clr_err         in   one-cycle pulse, clears ack_timeout_err
//   status_depth    in   FIFO m_status_depth [DW-1:0]
//   pause_req       out  to FIFO m_pause_req (registered)
//   pause_ack       in   from FIFO m_pause_ack
//   paused          out  1 while in PAUSED (registered)
//   ack_timeout_err out  sticky pause_ack handshake timeout
//   pause_cnt       out  completed pause entries
//   force_rel_cnt   out  hold-timeout releases
// ----------------------------------------------------------------------------
module taxi_axis_fifo_pause_ctrl #(
  parameter int DEPTH       = 4096,
  parameter int HI_WM       = DEPTH * 3 / 4,
  parameter int LO_WM       = DEPTH / 4,
  parameter int MAX_HOLD    = 4096,
  parameter int ACK_TIMEOUT = 256,
  localparam int DW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sw_pause,
  input  logic          clr_err,
  input  logic [DW-1:0] status_depth,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          paused,
  output logic          ack_timeout_err,
  output logic [31:0]   pause_cnt,
  output logic [31:0]   force_rel_cnt
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] PAUSING   = 2'd1;
  localparam logic [1:0] PAUSED    = 2'd2;
  localparam logic [1:0] RELEASING = 2'd3;

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] ack_cnt, ack_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          drain;
  logic          err_set;
  logic          pause_entry;
  logic          force_rel;

  logic depth_lo, depth_hi, depth_zero;
  assign depth_lo   = status_depth < DW'(LO_WM);
  assign depth_hi   = status_depth >= DW'(HI_WM);
  assign depth_zero = status_depth == '0;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    ack_cnt_nxt  = ack_cnt;
    hold_cnt_nxt = hold_cnt;
    err_set      = 1'b0;
    pause_entry  = 1'b0;
    force_rel    = 1'b0;
    case (state)
      RUN: begin
        ack_cnt_nxt = '0;
        // drain only masks the watermark trigger; software pause always wins
        if (sw_pause || (enable && !drain && depth_lo)) state_nxt = PAUSING;
      end
      PAUSING: begin
        if (pause_ack) begin
          state_nxt   = PAUSED;
          ack_cnt_nxt = '0;
          pause_entry = 1'b1;
        end else if (ack_cnt == ACK_LAST) begin
          state_nxt   = RELEASING;
          ack_cnt_nxt = '0;
          err_set     = 1'b1;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      PAUSED: begin
        ack_cnt_nxt = '0;
        // an empty FIFO does not age the hold; saturate at the release point
        if (!depth_zero && hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
        if (!sw_pause) begin
          if (depth_hi) begin
            state_nxt    = RELEASING;
            hold_cnt_nxt = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt    = RELEASING;
            hold_cnt_nxt = '0;
            force_rel    = 1'b1;
          end else if (!enable) begin
            state_nxt    = RELEASING;
            hold_cnt_nxt = '0;
          end
        end
      end
      RELEASING: begin
        if (!pause_ack) begin
          state_nxt   = RUN;
          ack_cnt_nxt = '0;
        end else if (ack_cnt == ACK_LAST) begin
          state_nxt   = RUN;
          ack_cnt_nxt = '0;
          err_set     = 1'b1;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      ack_cnt         <= '0;
      hold_cnt        <= '0;
      drain           <= 1'b0;
      pause_req       <= 1'b0;
      paused          <= 1'b0;
      ack_timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack_cnt   <= ack_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      // outputs decoded from the next state so they change one cycle after
      // the decision, with no combinational path to the FIFO
      pause_req <= (state_nxt == PAUSING) || (state_nxt == PAUSED);
      paused    <= (state_nxt == PAUSED);
      // a fresh timeout beats a coincident clear
      if (err_set)      ack_timeout_err <= 1'b1;
      else if (clr_err) ack_timeout_err <= 1'b0;
      // an empty FIFO ends the drain phase; nothing left to protect
      if (depth_zero)     drain <= 1'b0;
      else if (force_rel) drain <= 1'b1;
    end
  end

`ifdef TAXI_PAUSE_CTRL_STATS_EN
  logic [31:0] pause_cnt_q;
  logic [31:0] force_rel_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_cnt_q     <= '0;
      force_rel_cnt_q <= '0;
    end else begin
      if (pause_entry) pause_cnt_q     <= pause_cnt_q + 32'd1;
      if (force_rel)   force_rel_cnt_q <= force_rel_cnt_q + 32'd1;
    end
  end

  assign pause_cnt     = pause_cnt_q;
  assign force_rel_cnt = force_rel_cnt_q;
`else
  logic stats_unused;
  assign stats_unused  = pause_entry ^ force_rel;
  assign pause_cnt     = 32'd0;
  assign force_rel_cnt = 32'd0;
`endif

endmodule
